// File: rtl/serial_deserializer_if.sv
// Serial input and buffered parallel output of the serial deserializer.
// The master drives the serial stream and consumes words; the slave is the deserializer.
interface serial_deserializer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_bit;
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overflow;
  logic              clr_ovf;

  modport master (
    output in_bit, in_valid, in_sof, out_ready, clr_ovf,
    input  out_data, out_valid, frame_err, overflow
  );

  modport slave (
    input  in_bit, in_valid, in_sof, out_ready, clr_ovf,
    output out_data, out_valid, frame_err, overflow
  );
endinterface

// File: rtl/serial_deserializer.sv
// Reassembles sof-aligned serial words into DATA_W-bit words.
// Completed words are buffered in a small FIFO with a valid/ready output.
module serial_deserializer #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_deserializer_if.slave bus
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCW = AW + 1;
  localparam int unsigned CW  = $clog2(DATA_W + 1);

  typedef enum logic {
    HUNT,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              ferr_q, ferr_d;
  logic              push;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]    occ_q, occ_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;

  logic              pop;
  logic              full;
  logic              push_ok;
  logic              ovf_set;

  function automatic logic [DATA_W-1:0] insert_bit(input logic [DATA_W-1:0] base,
                                                   input logic              b);
    if (MSB_FIRST) begin
      return {base[DATA_W-2:0], b};
    end else begin
      return {b, base[DATA_W-1:1]};
    end
  endfunction

  // count==0 in SHIFT means a word just completed and the next must start with sof.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.in_sof) begin
            shreg_d = insert_bit('0, bus.in_bit);
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.in_sof) begin
            ferr_d  = (cnt_q != '0);
            shreg_d = insert_bit('0, bus.in_bit);
            cnt_d   = CW'(1);
          end else if (cnt_q == '0) begin
            state_d = HUNT;
          end else begin
            shreg_d = insert_bit(shreg_q, bus.in_bit);
            if (cnt_q == CW'(DATA_W - 1)) begin
              push  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // A push into a full FIFO survives only if the head leaves on the same edge.
  always_comb begin
    pop      = (occ_q != '0) && bus.out_ready;
    full     = (occ_q == OCW'(FIFO_DEPTH));
    push_ok  = push && (!full || pop);
    ovf_set  = push && full && !pop;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shreg_d;
    end
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + OCW'(push_ok) - OCW'(pop);
    last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    ovf_d    = ovf_set | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      shreg_q  <= '0;
      ferr_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ferr_q   <= ferr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // When empty, out_data shows the most recently popped word.
  assign bus.out_data  = (occ_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign bus.out_valid = (occ_q != '0);
  assign bus.frame_err = ferr_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Downstream partner of the 8-bit serializer: samples a serial bit stream one bit per qualified clock and reassembles parallel words.
- Word alignment comes from a start-of-frame strobe on the first bit of each word.
- Completed words are buffered in a small FIFO and handed to the consumer over a valid/ready interface.
- Sits between the serial link and the byte-wide processing logic.

Parameters:
- DATA_W, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 = first received bit lands in bit DATA_W-1; 0 = first received bit lands in bit 0.
- FIFO_DEPTH, 4, output buffer depth in words; must be a power of 2, 2 or more.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is sampled on this edge only when in_valid=1.
- in_sof  in  1  marks in_bit as bit 0 of a new word; ignored unless in_valid=1.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word when out_valid=1 and out_ready=1.
- frame_err  out  1  one-cycle pulse: a word was aborted by an early in_sof.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release; clk must run): state=HUNT; bit counter=0; shift register=0; FIFO empty.
  - Outputs after reset: out_valid=0, out_data=0, frame_err=0, overflow=0.
  - Reset asserted mid-word discards the partial word and all FIFO contents.
- FSM states:
  - HUNT:
    - Bits with in_valid=1 and in_sof=0 are ignored.
    - in_valid=1 with in_sof=1: capture the bit, set count=1, go to SHIFT.
  - SHIFT, on each in_valid=1:
    - in_sof=0: capture the bit, count+1.
    - in_sof=1 with count between 1 and DATA_W-1: frame_err pulses on the next cycle. Drop the partial word, restart with this bit, count=1, stay in SHIFT.
    - When the captured bit makes count=DATA_W, the assembled word is pushed on that same edge and count returns to 0.
    - The next word's bit 0 must arrive with in_sof=1. A non-sof bit at count=0 returns the FSM to HUNT and is discarded (no frame_err).
  - in_valid=0: hold all state; gaps of any length are allowed inside a word.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit into the LSB. After DATA_W bits, the first bit is the MSB.
  - MSB_FIRST=0: shift right, new bit into the MSB. After DATA_W bits, the first bit is the LSB.
- Latency: the word is visible at out_data with out_valid=1 in the cycle right after the edge that sampled its last bit, when the FIFO was empty. Sustained input rate is 1 word per DATA_W clocks.
- FIFO:
  - Pop happens on the edge where out_valid and out_ready are both 1.
  - out_data is the head word, combinationally valid whenever out_valid=1.
  - When empty, out_data holds the last popped value (0 after reset).
  - out_ready while empty has no effect.
- Full-FIFO boundary:
  - Push while full with no pop: the word is dropped and overflow sets.
  - Push and pop on the same edge while full: push accepted, no overflow, occupancy unchanged.
  - Push and pop on the same edge while empty is not possible: the pushed word is first visible on the next cycle.
- overflow stays set until clr_ovf=1. If clr_ovf and a new overflow occur on the same edge, overflow stays 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.

Test Plan:
- Basic MSB-first: defaults, out_ready=1. Send bits 0,1,0,1,0,0,1,1 with in_sof on the first bit -> out_data=8'h53, out_valid=1 for exactly 1 cycle, starting one cycle after the 8th bit. Then send 8'hCF the same way -> 8'hCF.
- Gaps and HUNT: 3 bits without in_sof after reset, then 8'hA5 with in_valid toggling 1/0 -> the first 3 bits are ignored, a single word 8'hA5 appears, frame_err never pulses.
- Overflow and backpressure: out_ready=0, send 8'h01..8'h05 -> the FIFO holds 01..04 and overflow=1. Raise out_ready -> 01,02,03,04 pop on consecutive cycles and out_valid falls. Pulse clr_ovf -> overflow=0.
- Early sof: after 5 bits of a word, assert in_sof and send 8'h3C -> one frame_err pulse, then out_data=8'h3C only (the partial word is never output).
- Reset mid-operation: 2 words in the FIFO and 4 bits of a third in flight, assert rst_n=0 asynchronously between edges -> out_valid=0, overflow=0 immediately. After release, a 4-bit tail without in_sof produces no word.
- LSB-first: MSB_FIRST=0, send bits 1,1,0,0,1,0,1,0 -> out_data=8'h53.
